// File: rtl/alu_regheap_sequencer.sv
// alu_regheap_sequencer: FIFO-buffered micro-op sequencer for the register-heap + ALU datapath (SEQ_X0_GUARD_EN blocks writes to r0)
module alu_regheap_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [4:0]       cmd_addr_a,
    input  logic [4:0]       cmd_addr_b,
    input  logic [4:0]       cmd_w_addr,
    input  logic             cmd_we,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_res,
    output logic [3:0]       rsp_flags,
    output logic [4:0]       rsp_w_addr,
    output logic [4:0]       r_addr_a,
    output logic [4:0]       r_addr_b,
    output logic [4:0]       w_addr,
    output logic [3:0]       alu_op,
    output logic             w_en,
    output logic             reg_clk,
    output logic             alu_clk,
    input  logic [31:0]      alu_res,
    input  logic [3:0]       alu_flags,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [2:0] {IDLE, READ, EXEC, WB, RESP} state_t;
    typedef struct packed {
        logic [3:0] op;
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] w;
        logic       we;
    } cmd_t;
    cmd_t             mem_q [DEPTH];
    cmd_t             cmd_q, cmd_d;
    state_t           state_q, state_d;
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             alu_clk_q, alu_clk_d, reg_clk_q, reg_clk_d, w_en_q, w_en_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_res_q, rsp_res_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;
    logic [4:0]       rsp_w_addr_q, rsp_w_addr_d;
    logic             push, pop, x0_ok;
`ifdef SEQ_X0_GUARD_EN
    assign x0_ok = cmd_q.w != 5'd0;
`else
    assign x0_ok = 1'b1;
`endif
    assign cmd_ready  = cnt_q != CNT_W'(DEPTH);
    assign push       = cmd_valid && cmd_ready;
    assign pop        = state_q == IDLE && cnt_q != '0;
    assign busy       = state_q != IDLE || cnt_q != '0;
    assign fifo_count = cnt_q;
    assign r_addr_a   = cmd_q.a;
    assign r_addr_b   = cmd_q.b;
    assign w_addr     = cmd_q.w;
    assign alu_op     = cmd_q.op;
    assign alu_clk    = alu_clk_q;
    assign reg_clk    = reg_clk_q;
    assign w_en       = w_en_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_res    = rsp_res_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_w_addr = rsp_w_addr_q;
    always_comb begin
        wr_d         = push ? wr_q + AW'(1) : wr_q;
        rd_d         = pop ? rd_q + AW'(1) : rd_q;
        cnt_d        = cnt_q + CNT_W'(push) - CNT_W'(pop);
        cmd_d        = pop ? mem_q[rd_q] : cmd_q;
        state_d      = state_q == IDLE ? (pop ? READ : IDLE) :
                       state_q == READ ? EXEC :
                       state_q == EXEC ? WB :
                       state_q == WB   ? RESP :
                       rsp_ready       ? IDLE : RESP;
        alu_clk_d    = state_q == READ;
        reg_clk_d    = state_q == EXEC;
        w_en_d       = state_q == EXEC && cmd_q.we && x0_ok;
        rsp_valid_d  = state_q == WB || (state_q == RESP && !rsp_ready);
        rsp_res_d    = state_q == WB ? alu_res : rsp_res_q;
        rsp_flags_d  = state_q == WB ? alu_flags : rsp_flags_q;
        rsp_w_addr_d = state_q == WB ? cmd_q.w : rsp_w_addr_q;
    end
    always_ff @(posedge clk)
        if (push) mem_q[wr_q] <= '{op: cmd_op, a: cmd_addr_a, b: cmd_addr_b, w: cmd_w_addr, we: cmd_we};
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            alu_clk_q    <= 1'b0;
            reg_clk_q    <= 1'b0;
            w_en_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_res_q    <= '0;
            rsp_flags_q  <= '0;
            rsp_w_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            alu_clk_q    <= alu_clk_d;
            reg_clk_q    <= reg_clk_d;
            w_en_q       <= w_en_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_res_q    <= rsp_res_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_w_addr_q <= rsp_w_addr_d;
        end
    end
endmodule
